// File: rtl/inst_writer.sv
// Instruction writer: encodes LC-3b field bundles into 16-bit words, queues them in a FIFO
// and writes them to consecutive word addresses. Optional readback verify: INST_WRITER_READBACK_EN.
module inst_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  dest,
  input  logic [2:0]  src1,
  input  logic [2:0]  src2,
  input  logic [5:0]  offset6,
  input  logic [8:0]  offset9,
  input  logic [10:0] offset11,
  input  logic [4:0]  imm5,
  input  logic        imm5_enable,
  input  logic        offset11_enable,
  input  logic [7:0]  trapvect8,
  input  logic        a_bit,
  input  logic        d_bit,
  input  logic        load_base,
  input  logic [15:0] base_addr,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy,
  output logic [15:0] words_written,
  output logic        mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDW  = 4'h6;
  localparam logic [3:0] OP_STW  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

`ifdef INST_WRITER_READBACK_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_VERIFY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRITE = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [15:0]   enc_word;
  logic [15:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   ww_q, ww_d;
  logic          push, pop, load_ok;

  always_comb begin
    enc_word = 16'h0000;
    case (opcode)
      OP_ADD, OP_AND:
        enc_word = {opcode, dest, src1, imm5_enable, imm5_enable ? imm5 : {2'b00, src2}};
      OP_NOT:  enc_word = {opcode, dest, src1, 6'h3F};
      OP_BR, OP_LEA:
        enc_word = {opcode, dest, offset9};
      OP_JMP:  enc_word = {opcode, 3'b000, src1, 6'h00};
      OP_JSR:
        enc_word = offset11_enable ? {opcode, 1'b1, offset11} : {opcode, 3'b000, src1, 6'h00};
      OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI:
        enc_word = {opcode, dest, src1, offset6};
      OP_SHF:  enc_word = {opcode, dest, src1, d_bit, a_bit, imm5[3:0]};
      OP_TRAP: enc_word = {opcode, 4'h0, trapvect8};
      OP_RTI:  enc_word = 16'h8000;
      default: enc_word = 16'h0000;
    endcase
  end

  // A full FIFO refuses input even when the head leaves this cycle, so in_ready
  // depends only on registered occupancy.
  assign in_ready = (cnt_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_WRITE) && mem_resp;
  assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign load_ok  = load_base && (state_q == ST_IDLE) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    ww_d   = ww_q;
    if (load_ok) begin
      addr_d = {base_addr[15:1], 1'b0};
      ww_d   = 16'h0000;
    end else if (pop) begin
      addr_d = addr_q + 16'd2;
      ww_d   = ww_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= 16'h0000;
      ww_q   <= 16'h0000;
    end else begin
      addr_q <= addr_d;
      ww_q   <= ww_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state looks at post-update occupancy so an enqueue into an idle
  // writer, or a refill during the final write, starts a write next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_d != '0) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_resp) begin
`ifdef INST_WRITER_READBACK_EN
          state_d = ST_VERIFY;
`else
          state_d = (cnt_d != '0) ? ST_WRITE : ST_IDLE;
`endif
        end
      end
`ifdef INST_WRITER_READBACK_EN
      ST_VERIFY: begin
        if (mem_resp) state_d = (cnt_d != '0) ? ST_WRITE : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = addr_q;
    case (state_q)
      ST_WRITE: mem_write = 1'b1;
`ifdef INST_WRITER_READBACK_EN
      ST_VERIFY: begin
        mem_read    = 1'b1;
        mem_address = addr_q - 16'd2;
      end
`endif
      default: ;
    endcase
  end

  assign mem_wdata       = fifo_q[rd_ptr_q];
  assign mem_byte_enable = 2'b11;
  assign busy            = (cnt_q != '0) || (state_q != ST_IDLE);
  assign words_written   = ww_q;

`ifdef INST_WRITER_READBACK_EN
  logic [15:0] vdata_q;
  logic        mismatch_q;

  always_ff @(posedge clk) begin
    if (pop) vdata_q <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      mismatch_q <= 1'b0;
    else if (load_ok)
      mismatch_q <= 1'b0;
    else if ((state_q == ST_VERIFY) && mem_resp && (mem_rdata != vdata_q))
      mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_writer.sv
// Scoreboard bench for inst_writer: stimulus queues expected {address, word} pairs,
// a memory responder pops and compares each write it completes.
`timescale 1ns/1ps
module tb_inst_writer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  dest, src1, src2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [4:0]  imm5;
  logic        imm5_enable, offset11_enable;
  logic [7:0]  trapvect8;
  logic        a_bit, d_bit;
  logic        load_base;
  logic [15:0] base_addr;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, mem_resp;
  logic [1:0]  mem_byte_enable;
  logic        busy;
  logic [15:0] words_written;
  logic        mismatch;

  always #5 clk = ~clk;

  inst_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .offset11(offset11), .imm5(imm5),
    .imm5_enable(imm5_enable), .offset11_enable(offset11_enable),
    .trapvect8(trapvect8), .a_bit(a_bit), .d_bit(d_bit),
    .load_base(load_base), .base_addr(base_addr),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy), .words_written(words_written), .mismatch(mismatch)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  logic        hold_resp = 1'b0;
  logic        corrupt = 1'b0;
  logic [15:0] exp_addr = 16'h0000;
  logic [15:0] last_wr_addr = 16'h0000;
  logic [15:0] mem_m [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder and scoreboard monitor: zero-wait memory unless held.
  initial begin
    wr_t e;
    mem_resp  = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (!reset && !hold_resp && (mem_write || mem_read)) begin
        mem_resp = 1'b1;
        if (mem_write) begin
          check("wr_byte_enable", {30'd0, mem_byte_enable}, 32'h3);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_address, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {16'd0, mem_address}, {16'd0, e.addr});
            check("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
          end
          mem_m[mem_address] = mem_wdata;
          last_wr_addr = mem_address;
          wr_cyc_q.push_back(cyc);
        end else begin
          check("rd_addr", {16'd0, mem_address}, {16'd0, last_wr_addr});
          mem_rdata = corrupt ? 16'h0000 : mem_m[mem_address];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 1'b0; opcode = 4'h0; dest = 3'd0; src1 = 3'd0; src2 = 3'd0;
    offset6 = 6'd0; offset9 = 9'd0; offset11 = 11'd0; imm5 = 5'd0;
    imm5_enable = 1'b0; offset11_enable = 1'b0; trapvect8 = 8'd0;
    a_bit = 1'b0; d_bit = 1'b0;
  endtask

  task automatic send(input logic [15:0] word, input bit expect_write);
    bit  acc;
    wr_t w;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h never accepted", word);
    end else if (expect_write) begin
      w.addr = exp_addr;
      w.data = word;
      exp_q.push_back(w);
      exp_addr = exp_addr + 16'd2;
    end
  endtask

  task automatic load(input logic [15:0] base);
    load_base = 1'b1;
    base_addr = base;
    tick();
    load_base = 1'b0;
    exp_addr = {base[15:1], 1'b0};
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    logic [15:0] first_addr;
    clr();
    reset = 1'b1; load_base = 1'b0; base_addr = 16'h0000;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_words", {16'd0, words_written}, 32'd0);
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
    tick();
    reset = 1'b0;

    // ADD immediate, single write with one-cycle latency
    load(16'h3000);
    opcode = 4'h1; dest = 3'd1; src1 = 3'd2; imm5_enable = 1'b1; imm5 = 5'h1F;
    send(16'h12BF, 1'b1);
    @(negedge clk);
    check("latency_n1", {31'd0, mem_write}, 32'd1);
    clr();
    wait_idle("idle_add");
    check("words_after_add", {16'd0, words_written}, 32'd1);

    // TRAP then JSR back to back; dest ignored for both
    wr_cyc_q.delete();
    clr(); opcode = 4'hF; dest = 3'd7; trapvect8 = 8'h25;
    send(16'hF025, 1'b1);
    clr(); opcode = 4'h4; dest = 3'd7; offset11_enable = 1'b1; offset11 = 11'h7FF;
    send(16'h4FFF, 1'b1);
    clr();
    wait_idle("idle_trap_jsr");
    if (wr_cyc_q.size() == 2) begin
`ifdef INST_WRITER_READBACK_EN
      check("write_spacing", wr_cyc_q[1] - wr_cyc_q[0], 32'd2);
`else
      check("write_spacing", wr_cyc_q[1] - wr_cyc_q[0], 32'd1);
`endif
    end else begin
      check("write_count_trap_jsr", wr_cyc_q.size(), 32'd2);
    end
    check("words_after_jsr", {16'd0, words_written}, 32'd3);

    // NOT and SHF
    clr(); opcode = 4'h9; dest = 3'd3; src1 = 3'd4; src2 = 3'd5; imm5 = 5'h0A;
    send(16'h973F, 1'b1);
    clr(); opcode = 4'hD; dest = 3'd1; src1 = 3'd2; d_bit = 1'b1; a_bit = 1'b1; imm5 = 5'h03;
    send(16'hD2B3, 1'b1);
    clr();
    wait_idle("idle_not_shf");
    check("words_after_shf", {16'd0, words_written}, 32'd5);

    // Fill the FIFO while memory stalls, then drain
    hold_resp = 1'b1;
    first_addr = exp_addr;
    clr(); opcode = 4'h0; dest = 3'd7; offset9 = 9'h1FF;
    send(16'h0FFF, 1'b1);
    clr(); opcode = 4'hE; dest = 3'd2; offset9 = 9'h005;
    send(16'hE405, 1'b1);
    clr(); opcode = 4'hC; dest = 3'd5; src1 = 3'd7;
    send(16'hC1C0, 1'b1);
    clr(); opcode = 4'h6; dest = 3'd5; src1 = 3'd6; offset6 = 6'h2A;
    send(16'h6BAA, 1'b1);
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_mem_write", {31'd0, mem_write}, 32'd1);
    check("stall_addr", {16'd0, mem_address}, {16'd0, first_addr});
    check("stall_wdata", {16'd0, mem_wdata}, 32'h0FFF);
    clr(); opcode = 4'h5; dest = 3'd1; src1 = 3'd2; src2 = 3'd3; imm5 = 5'h1F;
    fork
      send(16'h5283, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        tick();
        load_base = 1'b1;
        base_addr = 16'h1234;
        tick();
        load_base = 1'b0;
        @(negedge clk);
        check("busy_load_ignored", {16'd0, mem_address}, {16'd0, first_addr});
        tick();
        hold_resp = 1'b0;
      end
    join
    clr();
    wait_idle("idle_fill");
    check("words_after_fill", {16'd0, words_written}, 32'd10);

    // Address wrap; base bit 0 forced low
    load(16'hFFFF);
    check("load_clears_words", {16'd0, words_written}, 32'd0);
    clr(); opcode = 4'h8; dest = 3'd3;
    send(16'h8000, 1'b1);
    clr(); opcode = 4'h4; dest = 3'd7; src1 = 3'd3; offset11 = 11'h155;
    send(16'h40C0, 1'b1);
    clr(); opcode = 4'h3; dest = 3'd4; src1 = 3'd1; offset6 = 6'h3F;
    send(16'h387F, 1'b1);
    clr();
    wait_idle("idle_wrap");
    check("words_after_wrap", {16'd0, words_written}, 32'd3);

    // Reset while a write is outstanding
    hold_resp = 1'b1;
    clr(); opcode = 4'h1; dest = 3'd2; src1 = 3'd3; src2 = 3'd4;
    send(16'h14C4, 1'b0);
    clr();
    @(negedge clk);
    check("pre_reset_write", {31'd0, mem_write}, 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_mem_write", {31'd0, mem_write}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_words", {16'd0, words_written}, 32'd0);
    tick();
    reset = 1'b0;
    exp_addr = 16'h0000;
    hold_resp = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    tick();

    // Readback compare
    load(16'h3000);
    corrupt = 1'b1;
    clr(); opcode = 4'h1; dest = 3'd1; src1 = 3'd2; imm5_enable = 1'b1; imm5 = 5'h1F;
    send(16'h12BF, 1'b1);
    clr();
    wait_idle("idle_rb1");
`ifdef INST_WRITER_READBACK_EN
    check("mismatch_set", {31'd0, mismatch}, 32'd1);
`else
    check("mismatch_off", {31'd0, mismatch}, 32'd0);
    check("mem_read_off", {31'd0, mem_read}, 32'd0);
`endif
    corrupt = 1'b0;
    clr(); opcode = 4'h9; dest = 3'd3; src1 = 3'd4;
    send(16'h973F, 1'b1);
    clr();
    wait_idle("idle_rb2");
`ifdef INST_WRITER_READBACK_EN
    check("mismatch_sticky", {31'd0, mismatch}, 32'd1);
`else
    check("mismatch_still_off", {31'd0, mismatch}, 32'd0);
`endif
    load(16'h3000);
    @(negedge clk);
    check("mismatch_cleared", {31'd0, mismatch}, 32'd0);
    check("words_after_reload", {16'd0, words_written}, 32'd0);
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
